// File: rtl/pacc_arbiter.sv
// pacc_arbiter: round-robin sharing of the PACC engine between enc and dec requesters
module pacc_arbiter #(
   parameter int DATA_W         = 128,
   parameter int ENC_BEATS      = 96,
   parameter int DEC_BEATS      = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enc_req,
   input  logic              dec_req,
   output logic              enc_grant,
   output logic              dec_grant,
   output logic              enc_done,
   output logic              dec_done,
   output logic              pacc_enable,
   output logic              pacc_mux_enc_dec,
   input  logic              pacc_function_done,
   input  logic              pacc_outready,
   input  logic [7:0]        pacc_wad,
   input  logic [DATA_W-1:0] pacc_wdata,
   output logic              enc_wr_en,
   output logic              dec_wr_en,
   output logic [7:0]        wr_ad,
   output logic [DATA_W-1:0] wr_data,
   input  logic              err_clr,
   output logic              err_beats,
   output logic              err_timeout
);
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t state, state_nx;
   logic owner, owner_nx, last_owner, timed_out;
   logic [7:0] beat_cnt, beat_cnt_nx, beats_exp;
   logic [15:0] wdog;
   logic to_hit, to_set, beat, stray, in_win, beats_set;
   always_comb begin
      owner_nx    = (enc_req && dec_req) ? ~last_owner : dec_req;
      to_hit      = wdog == TO_LAST;
      to_set      = state == BUSY && to_hit && !pacc_function_done;
      beat        = pacc_outready && (state == BUSY || state == DONE);
      stray       = pacc_outready && (state == IDLE || state == ISSUE);
      in_win      = pacc_wad[7:5] == 3'b100 || (!owner && pacc_wad >= 8'd32 && pacc_wad <= 8'd95);
      beat_cnt_nx = (beat && beat_cnt != 8'hff) ? beat_cnt + 8'd1 : beat_cnt;
      beats_exp   = owner ? 8'(DEC_BEATS) : 8'(ENC_BEATS);
      // the count check includes a late beat arriving in the DONE cycle itself
      beats_set   = stray || (beat && !in_win) ||
                    (state == DONE && !timed_out && beat_cnt_nx != beats_exp);
      enc_grant        = state != IDLE && !owner;
      dec_grant        = state != IDLE && owner;
      pacc_mux_enc_dec = state != IDLE && owner;
      pacc_enable      = state == ISSUE;
      enc_done         = state == DONE && !owner;
      dec_done         = state == DONE && owner;
      unique case (state)
         IDLE:    state_nx = (enc_req || dec_req) ? ISSUE : IDLE;
         ISSUE:   state_nx = BUSY;
         BUSY:    state_nx = (pacc_function_done || to_hit) ? DONE : BUSY;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         timed_out   <= 1'b0;
         beat_cnt    <= '0;
         wdog        <= '0;
         enc_wr_en   <= 1'b0;
         dec_wr_en   <= 1'b0;
         wr_ad       <= '0;
         wr_data     <= '0;
         err_beats   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         owner       <= (state == IDLE) ? owner_nx : owner;
         last_owner  <= (state == DONE) ? owner : last_owner;
         timed_out   <= (state == ISSUE) ? 1'b0 : timed_out | to_set;
         beat_cnt    <= (state == ISSUE) ? '0 : beat_cnt_nx;
         wdog        <= (state == ISSUE) ? '0 : (state == BUSY) ? wdog + 16'd1 : wdog;
         enc_wr_en   <= beat && in_win && !owner;
         dec_wr_en   <= beat && in_win && owner;
         wr_ad       <= beat ? pacc_wad : wr_ad;
         wr_data     <= beat ? pacc_wdata : wr_data;
         err_beats   <= beats_set | (err_beats & ~err_clr);
         err_timeout <= to_set | (err_timeout & ~err_clr);
      end
   end
endmodule

// File: tb/tb_pacc_arbiter.sv
// tb_pacc_arbiter: engine model plus write-stream scoreboard for pacc_arbiter
module tb_pacc_arbiter;
   localparam int DW = 128;
   localparam int TO = 128;
   logic clk = 0, rst_n = 0, enc_req = 0, dec_req = 0, err_clr = 0;
   logic pacc_function_done = 0, pacc_outready = 0;
   logic [7:0] pacc_wad = 0;
   logic [DW-1:0] pacc_wdata = 0;
   logic enc_grant, dec_grant, enc_done, dec_done, pacc_enable, pacc_mux_enc_dec;
   logic enc_wr_en, dec_wr_en, err_beats, err_timeout;
   logic [7:0] wr_ad;
   logic [DW-1:0] wr_data;
   int checks = 0, errors = 0, en_cnt = 0, done_cnt = 0, overlap = 0;
   logic [137:0] sb[$];

   pacc_arbiter #(.DATA_W(DW), .ENC_BEATS(96), .DEC_BEATS(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .enc_req(enc_req), .dec_req(dec_req),
      .enc_grant(enc_grant), .dec_grant(dec_grant), .enc_done(enc_done), .dec_done(dec_done),
      .pacc_enable(pacc_enable), .pacc_mux_enc_dec(pacc_mux_enc_dec),
      .pacc_function_done(pacc_function_done), .pacc_outready(pacc_outready),
      .pacc_wad(pacc_wad), .pacc_wdata(pacc_wdata), .enc_wr_en(enc_wr_en), .dec_wr_en(dec_wr_en),
      .wr_ad(wr_ad), .wr_data(wr_data), .err_clr(err_clr), .err_beats(err_beats),
      .err_timeout(err_timeout));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (pacc_enable) en_cnt++;
      if (enc_done || dec_done) done_cnt++;
      if (enc_grant && dec_grant) overlap++;
      if (enc_wr_en || dec_wr_en) begin
         if (sb.size() == 0) chk("wr_unexpected", {dec_wr_en, enc_wr_en, wr_ad}, 0);
         else chk("wr_beat", {dec_wr_en, enc_wr_en, wr_ad, wr_data}, sb.pop_front());
      end
   end

   task automatic do_reset();
      rst_n = 0;
      {enc_req, dec_req, err_clr, pacc_function_done, pacc_outready} = '0;
      step();
      step();
      rst_n = 1;
   endtask

   // one engine job: own 0=enc 1=dec; bad = beat index sent at wad 40 (-1 none); fin = engine sends done
   task automatic do_job(input bit own, input int nb, input int bad, input bit fin, output int n);
      logic [7:0] a;
      logic [DW-1:0] d;
      n = 0;
      for (int k = 0; k < 8 && !(enc_grant || dec_grant); k++) step();
      if (!(enc_grant || dec_grant)) begin
         chk("grant_wait", 0, 1);
         return;
      end
      chk("grant", {dec_grant, enc_grant}, own ? 2'b10 : 2'b01);
      chk("mux", pacc_mux_enc_dec, own);
      chk("enable_issue", pacc_enable, 1);
      step();
      n++;
      chk("enable_busy", pacc_enable, 0);
      for (int i = 0; i < nb; i++) begin
         a = (i == bad) ? 8'd40 : (own || i < 32) ? 8'(128 + i % 32) : 8'(i);
         d = {$urandom, $urandom, $urandom, $urandom};
         pacc_outready = 1;
         pacc_wad = a;
         pacc_wdata = d;
         if ((a >= 128 && a <= 159) || (!own && a >= 32 && a <= 95))
            sb.push_back({own, !own, a, d});
         step();
         n++;
      end
      pacc_outready = 0;
      if (fin) begin
         pacc_function_done = 1;
         step();
         n++;
         pacc_function_done = 0;
      end else begin
         while (!(enc_done || dec_done) && n < TO + 20) begin
            step();
            n++;
         end
      end
      chk("done", {dec_done, enc_done}, own ? 2'b10 : 2'b01);
      step();
      chk("release", {dec_grant, enc_grant, pacc_mux_enc_dec, dec_done, enc_done}, 0);
      chk("sb_drain", sb.size(), 0);
   endtask

   initial begin
      int n, e0, d0;
      do_reset();
      chk("reset_out", {enc_grant, dec_grant, enc_done, dec_done, pacc_enable, pacc_mux_enc_dec,
                        enc_wr_en, dec_wr_en, wr_ad, wr_data, err_beats, err_timeout}, 0);
      enc_req = 1;
      do_job(0, 96, -1, 1, n);
      enc_req = 0;
      chk("enc_err_beats", err_beats, 0);
      do_reset();
      enc_req = 1;
      dec_req = 1;
      do_job(0, 96, -1, 1, n);
      enc_req = 0;
      do_job(1, 32, -1, 1, n);
      dec_req = 0;
      chk("tie_err_beats", err_beats, 0);
      do_reset();
      e0 = en_cnt;
      enc_req = 1;
      dec_req = 1;
      for (int j = 0; j < 4; j++) do_job(j % 2, j % 2 ? 32 : 96, -1, 1, n);
      enc_req = 0;
      dec_req = 0;
      step();
      step();
      chk("enable_count", en_cnt - e0, 4);
      chk("rr_err_beats", err_beats, 0);
      dec_req = 1;
      do_job(1, 31, -1, 1, n);
      dec_req = 0;
      chk("short_err", err_beats, 1);
      step();
      chk("sticky", err_beats, 1);
      err_clr = 1;
      step();
      err_clr = 0;
      chk("err_clr", err_beats, 0);
      dec_req = 1;
      do_job(1, 32, 5, 1, n);
      dec_req = 0;
      chk("window_err", err_beats, 1);
      err_clr = 1;
      step();
      err_clr = 0;
      chk("err_clr2", err_beats, 0);
      enc_req = 1;
      do_job(0, 10, -1, 0, n);
      enc_req = 0;
      chk("busy_cycles", n, TO + 1);
      chk("timeout_err", err_timeout, 1);
      chk("timeout_skip_beats", err_beats, 0);
      d0 = done_cnt;
      enc_req = 1;
      for (int k = 0; k < 8 && !enc_grant; k++) step();
      chk("abort_grant", enc_grant, 1);
      step();
      step();
      step();
      rst_n = 0;
      enc_req = 0;
      step();
      chk("abort_out", {enc_grant, dec_grant, enc_done, dec_done, pacc_enable, pacc_mux_enc_dec,
                        enc_wr_en, dec_wr_en, wr_ad, wr_data, err_beats, err_timeout}, 0);
      rst_n = 1;
      step();
      step();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("no_overlap", overlap, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end
endmodule
